// File: rtl/fdiv_arbiter_pkg.sv
// fdiv_arbiter_pkg: state encodings and port ids shared by the arbiter files
package fdiv_arbiter_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2,
        RESP  = 2'd3
    } state_t;
    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;
endpackage

// File: rtl/fdiv_arbiter_if.sv
// fdiv_arbiter_if: requester and shared-fdiv signals of the arbiter
interface fdiv_arbiter_if #(parameter int DATA_W = 32);
    logic              order0, order1;
    logic              accepted0, accepted1;
    logic              done0, done1;
    logic [DATA_W-1:0] rs1_0, rs2_0, rs1_1, rs2_1;
    logic [DATA_W-1:0] rd0, rd1;
    logic              u_order, u_accepted, u_done;
    logic [DATA_W-1:0] u_rs1, u_rs2, u_rd;
    // environment side: requesters plus the fdiv unit
    modport master (
        output order0, order1, rs1_0, rs2_0, rs1_1, rs2_1, u_accepted, u_done, u_rd,
        input  accepted0, accepted1, done0, done1, rd0, rd1, u_order, u_rs1, u_rs2
    );
    // arbiter side
    modport slave (
        input  order0, order1, rs1_0, rs2_0, rs1_1, rs2_1, u_accepted, u_done, u_rd,
        output accepted0, accepted1, done0, done1, rd0, rd1, u_order, u_rs1, u_rs2
    );
endinterface

// File: rtl/fdiv_arbiter_rr_pick2.sv
// rr_pick2: two-way round-robin pick; on a tie the port that was not granted last wins
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant,
    output logic       gid
);
    assign grant = (req == 2'b11) ? (last ? 2'b01 : 2'b10) : req;
    assign gid   = grant[1];
endmodule

// File: rtl/fdiv_arbiter.sv
// fdiv_arbiter: shares one fdiv unit between two requesters, one operation in flight
module fdiv_arbiter
    import fdiv_arbiter_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input logic          clk,
    input logic          rstn,
    fdiv_arbiter_if.slave bus
);
    state_t            r_state, w_next;
    logic              r_gid, r_last;
    logic [DATA_W-1:0] r_rs1, r_rs2, r_rd0, r_rd1;
    logic [1:0]        w_req, w_grant, w_accept, w_done;
    logic              w_gid, w_u_order, w_cap, w_take;

    assign w_req = {bus.order1, bus.order0};

    rr_pick2 u_pick (
        .req   (w_req),
        .last  (r_last),
        .grant (w_grant),
        .gid   (w_gid)
    );

    // state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (|w_req) w_next = ISSUE;
            ISSUE:   if (bus.u_accepted) w_next = bus.u_done ? RESP : BUSY;
            BUSY:    if (bus.u_done) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // outputs decoded from state; accept is gated by reset so it reads 0 while rstn is low
    always_comb begin
        w_take    = (r_state == IDLE) && rstn && (|w_req);
        w_accept  = w_take ? w_grant : 2'b00;
        w_u_order = (r_state == ISSUE);
        w_done    = (r_state == RESP) ? ((r_gid == PORT1) ? 2'b10 : 2'b01) : 2'b00;
        w_cap     = ((r_state == ISSUE) && bus.u_accepted && bus.u_done) ||
                    ((r_state == BUSY) && bus.u_done);
    end

    // operand latch on accept, result capture into the owning port's register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_gid  <= PORT0;
            r_last <= PORT1;
            r_rs1  <= '0;
            r_rs2  <= '0;
            r_rd0  <= '0;
            r_rd1  <= '0;
        end else begin
            if (w_take) begin
                r_gid  <= w_gid;
                r_last <= w_gid;
                r_rs1  <= (w_gid == PORT1) ? bus.rs1_1 : bus.rs1_0;
                r_rs2  <= (w_gid == PORT1) ? bus.rs2_1 : bus.rs2_0;
            end
            if (w_cap && r_gid == PORT0) r_rd0 <= bus.u_rd;
            if (w_cap && r_gid == PORT1) r_rd1 <= bus.u_rd;
        end
    end

    assign bus.accepted0 = w_accept[0];
    assign bus.accepted1 = w_accept[1];
    assign bus.done0     = w_done[0];
    assign bus.done1     = w_done[1];
    assign bus.u_order   = w_u_order;
    assign bus.u_rs1     = r_rs1;
    assign bus.u_rs2     = r_rs2;
    assign bus.rd0       = r_rd0;
    assign bus.rd1       = r_rd1;
endmodule

// File: tb/tb_fdiv_arbiter.sv
// tb_fdiv_arbiter: directed checks of the two-port fdiv arbiter
module tb_fdiv_arbiter;
    logic clk, rstn;
    int   n_chk, n_fail;

    fdiv_arbiter_if #(.DATA_W(32)) bus ();

    fdiv_arbiter #(.DATA_W(32)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // fastest fdiv: accepts in ISSUE, answers next cycle; returns with the FSM in RESP
    task automatic fdiv_min(input logic [31:0] res);
        bus.u_accepted = 1'b1;
        tick();
        bus.u_accepted = 1'b0;
        bus.u_done = 1'b1;
        bus.u_rd = res;
        tick();
        bus.u_done = 1'b0;
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        rstn = 1'b0;
        bus.order0 = 0; bus.order1 = 0;
        bus.rs1_0 = 0; bus.rs2_0 = 0; bus.rs1_1 = 0; bus.rs2_1 = 0;
        bus.u_accepted = 0; bus.u_done = 0; bus.u_rd = 0;
        #1;
        chk("rst_acc", {30'd0, bus.accepted1, bus.accepted0}, 32'd0);
        chk("rst_done", {30'd0, bus.done1, bus.done0}, 32'd0);
        chk("rst_uorder", {31'd0, bus.u_order}, 32'd0);
        chk("rst_urs", bus.u_rs1 | bus.u_rs2, 32'd0);
        chk("rst_rd", bus.rd0 | bus.rd1, 32'd0);
        tick();
        tick();
        rstn = 1'b1;

        // single request on port 0, fdiv answers 10 cycles after accepting
        bus.order0 = 1; bus.rs1_0 = 32'h4080_0000; bus.rs2_0 = 32'h4000_0000;
        #1;
        chk("t1_acc0", {31'd0, bus.accepted0}, 32'd1);
        chk("t1_acc1", {31'd0, bus.accepted1}, 32'd0);
        tick();
        bus.order0 = 0;
        chk("t1_uorder", {31'd0, bus.u_order}, 32'd1);
        chk("t1_urs1", bus.u_rs1, 32'h4080_0000);
        chk("t1_urs2", bus.u_rs2, 32'h4000_0000);
        chk("t1_acc0_issue", {31'd0, bus.accepted0}, 32'd0);
        bus.u_accepted = 1;
        tick();
        bus.u_accepted = 0;
        chk("t1_uorder_busy", {31'd0, bus.u_order}, 32'd0);
        for (int i = 0; i < 9; i++) begin
            chk("t1_wait_done", {30'd0, bus.done1, bus.done0}, 32'd0);
            tick();
        end
        bus.u_done = 1; bus.u_rd = 32'h4000_0000;
        #1;
        chk("t1_done_early", {31'd0, bus.done0}, 32'd0);
        tick();
        bus.u_done = 0;
        chk("t1_done0", {31'd0, bus.done0}, 32'd1);
        chk("t1_done1", {31'd0, bus.done1}, 32'd0);
        chk("t1_rd0", bus.rd0, 32'h4000_0000);
        tick();
        chk("t1_done0_off", {31'd0, bus.done0}, 32'd0);

        // simultaneous requests straight out of reset: port 0 first
        rstn = 0;
        #1;
        rstn = 1;
        bus.order0 = 1; bus.rs1_0 = 32'h4120_0000; bus.rs2_0 = 32'h40A0_0000;
        bus.order1 = 1; bus.rs1_1 = 32'h3F80_0000; bus.rs2_1 = 32'h4080_0000;
        #1;
        chk("t2_acc", {30'd0, bus.accepted1, bus.accepted0}, 32'd1);
        tick();
        bus.order0 = 0;
        chk("t2_urs1_p0", bus.u_rs1, 32'h4120_0000);
        chk("t2_urs2_p0", bus.u_rs2, 32'h40A0_0000);
        chk("t2_acc1_held", {31'd0, bus.accepted1}, 32'd0);
        fdiv_min(32'h4000_0000);
        chk("t2_done_p0", {30'd0, bus.done1, bus.done0}, 32'd1);
        chk("t2_rd0", bus.rd0, 32'h4000_0000);
        tick();
        chk("t2_acc_p1", {30'd0, bus.accepted1, bus.accepted0}, 32'd2);
        tick();
        bus.order1 = 0;
        chk("t2_urs1_p1", bus.u_rs1, 32'h3F80_0000);
        chk("t2_urs2_p1", bus.u_rs2, 32'h4080_0000);
        fdiv_min(32'h3E80_0000);
        chk("t2_done_p1", {30'd0, bus.done1, bus.done0}, 32'd2);
        chk("t2_rd1", bus.rd1, 32'h3E80_0000);
        chk("t2_rd0_kept", bus.rd0, 32'h4000_0000);
        tick();

        // sustained contention: grants alternate starting with port 0
        bus.order0 = 1; bus.order1 = 1;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("t3_grant", {30'd0, bus.accepted1, bus.accepted0}, (i % 2) ? 32'd2 : 32'd1);
            tick();
            if (i % 2) bus.order1 = 0; else bus.order0 = 0;
            fdiv_min(32'h1000 + i);
            if (i % 2) bus.order1 = 1; else bus.order0 = 1;
            chk("t3_done", {30'd0, bus.done1, bus.done0}, (i % 2) ? 32'd2 : 32'd1);
            chk("t3_rd", (i % 2) ? bus.rd1 : bus.rd0, 32'h1000 + i);
            tick();
        end

        // back-pressure: fdiv withholds u_accepted for 5 cycles
        bus.rs1_0 = 32'h1111_1111; bus.rs2_0 = 32'h2222_2222;
        bus.rs1_1 = 32'h3333_3333; bus.rs2_1 = 32'h4444_4444;
        #1;
        chk("t4_acc0", {30'd0, bus.accepted1, bus.accepted0}, 32'd1);
        tick();
        bus.order0 = 0;
        for (int i = 0; i < 5; i++) begin
            chk("t4_uorder", {31'd0, bus.u_order}, 32'd1);
            chk("t4_urs1", bus.u_rs1, 32'h1111_1111);
            chk("t4_urs2", bus.u_rs2, 32'h2222_2222);
            chk("t4_acc1", {31'd0, bus.accepted1}, 32'd0);
            tick();
        end
        fdiv_min(32'h5555_5555);
        chk("t4_rd0", bus.rd0, 32'h5555_5555);
        tick();
        chk("t4_acc1_after", {31'd0, bus.accepted1}, 32'd1);
        tick();
        bus.order1 = 0;

        // reset while port 1 is in BUSY
        bus.u_accepted = 1;
        tick();
        bus.u_accepted = 0;
        tick();
        rstn = 0;
        bus.order1 = 1; bus.rs1_1 = 32'h0000_0007; bus.rs2_1 = 32'h0000_0009;
        #1;
        chk("t5_uorder", {31'd0, bus.u_order}, 32'd0);
        chk("t5_acc", {30'd0, bus.accepted1, bus.accepted0}, 32'd0);
        chk("t5_done", {30'd0, bus.done1, bus.done0}, 32'd0);
        chk("t5_urs", bus.u_rs1 | bus.u_rs2, 32'd0);
        chk("t5_rd", bus.rd0 | bus.rd1, 32'd0);
        tick();
        rstn = 1;
        #1;
        chk("t5_acc1_first", {30'd0, bus.accepted1, bus.accepted0}, 32'd2);
        tick();
        bus.order1 = 0;
        chk("t5_urs1", bus.u_rs1, 32'h0000_0007);
        chk("t5_no_done", {30'd0, bus.done1, bus.done0}, 32'd0);

        // u_accepted and u_done together in ISSUE: done two cycles after accept
        bus.u_accepted = 1; bus.u_done = 1; bus.u_rd = 32'hCAFE_BABE;
        #1;
        chk("t6_done_early", {30'd0, bus.done1, bus.done0}, 32'd0);
        tick();
        bus.u_accepted = 0; bus.u_done = 0;
        chk("t6_done1", {30'd0, bus.done1, bus.done0}, 32'd2);
        chk("t6_rd1", bus.rd1, 32'hCAFE_BABE);
        tick();
        chk("t6_done_off", {30'd0, bus.done1, bus.done0}, 32'd0);

        // stray u_done in IDLE
        bus.u_done = 1; bus.u_rd = 32'hDEAD_BEEF;
        tick();
        bus.u_done = 0;
        chk("t6_stray_done", {30'd0, bus.done1, bus.done0}, 32'd0);
        chk("t6_stray_rd1", bus.rd1, 32'hCAFE_BABE);
        chk("t6_stray_rd0", bus.rd0, 32'd0);
        chk("t6_stray_uorder", {31'd0, bus.u_order}, 32'd0);
        tick();
        chk("t6_stray_done2", {30'd0, bus.done1, bus.done0}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fdiv_arbiter.md
FDIV_ARBITER -- requirements
Module: fdiv_arbiter

Interface
REQ-001 Parameter DATA_W, default 32; operand and result width in bits.
REQ-002 Port clk, input, 1; the single clock, all state updates on its rising edge.
REQ-003 Port rstn, input, 1; reset, asynchronous and active-low.
REQ-004 Ports order0 / order1, input, 1; requester k asks for a divide and holds the line high until it sees accepted_k.
REQ-005 Ports accepted0 / accepted1, output, 1; one-cycle pulse, combinational, meaning the arbiter took requester k's operands this cycle.
REQ-006 Ports done0 / done1, output, 1; registered one-cycle pulse, meaning rd_k holds requester k's result.
REQ-007 Ports rs1_0, rs2_0, rs1_1, rs2_1, input, DATA_W; dividend and divisor, valid while order_k is high.
REQ-008 Ports rd0 / rd1, output, DATA_W; registered result, held stable until requester k's next done.
REQ-009 Port u_order, output, 1; request to the shared fdiv.
REQ-010 Port u_accepted, input, 1; fdiv took the operation.
REQ-011 Port u_done, input, 1; fdiv result is valid this cycle.
REQ-012 Ports u_rs1 / u_rs2, output, DATA_W; latched operands, stable from ISSUE until return to IDLE.
REQ-013 Port u_rd, input, DATA_W; fdiv result, sampled only when u_done is high.

Function
REQ-014 The FSM SHALL have four states: IDLE, ISSUE, BUSY and RESP.
REQ-015 IDLE: the arbiter SHALL leave IDLE only when order0 or order1 is high.
- Winner: the sole requester if one is high; if both are high, the one not equal to last_grant.
- Combinationally: accepted_winner=1, the other accepted=0.
- On the clock edge: latch the winner's rs1/rs2 into u_rs1/u_rs2, set gid to the winner, set last_grant to the winner, go to ISSUE.
REQ-016 accepted0 and accepted1 SHALL be 0 in every state other than IDLE, and never both 1.
REQ-017 u_order SHALL equal (state==ISSUE).
- ISSUE goes to BUSY on u_accepted.
- If u_accepted and u_done are both high in the same cycle, ISSUE goes directly to RESP and captures u_rd.
REQ-018 BUSY: on u_done, capture u_rd into rd_gid and go to RESP; the other rd SHALL be unchanged.
REQ-019 RESP: done_gid SHALL be 1 for exactly one cycle, then the FSM goes to IDLE.
- A new request can be accepted in the cycle after RESP.
REQ-020 Minimum latency: accept at cycle T, u_order at T+1; if u_accepted at T+1 and u_done at T+2, done at T+3.
REQ-021 u_done seen in IDLE or RESP SHALL be ignored.
REQ-022 order_k deasserting in ISSUE, BUSY or RESP SHALL have no effect on the operation in flight.
REQ-023 Only one operation SHALL be outstanding at a time; the arbiter adds no buffering.
REQ-024 Fairness: with both orders held continuously, grants SHALL alternate 0,1,0,1,...
REQ-025 Data SHALL pass through unmodified: no arithmetic and no special-casing of zero, NaN or denormal.

Reset
REQ-026 While rstn is low, the arbiter SHALL reset asynchronously to:
- state=IDLE, gid=0, last_grant=1 (so port 0 wins the first tie);
- u_order=0, done0=done1=0, accepted0=accepted1=0;
- u_rs1=u_rs2=0, rd0=rd1=0.
REQ-027 A reset in any state SHALL abandon the in-flight operation and never produce its done.
- The fdiv shares rstn.
- After rstn rises, the first accept is possible in the first cycle.

Structure
REQ-028 A shared package/include SHALL hold the state encodings (IDLE=2'd0, ISSUE=2'd1, BUSY=2'd2, RESP=2'd3) and the port-id constants PORT0=1'b0, PORT1=1'b1.
REQ-029 The round-robin choice SHALL be a separate combinational sub-module rr_pick2.
- Inputs: req[1:0], last.
- Outputs: grant[1:0] (one-hot or zero) and gid.
REQ-030 All other logic SHALL be in fdiv_arbiter; target size is 120 to 250 lines.

Verification
REQ-031 Single request:
- Stimulus: order0=1, rs1_0=0x40800000, rs2_0=0x40000000; fdiv model accepts immediately and answers 10 cycles later.
- Required: accepted0 in the same cycle; rd0=0x40000000 with done0 one cycle after u_done; done1 never.
REQ-032 Simultaneous requests from reset:
- Stimulus: port 0 divides 0x41200000 by 0x40A00000; port 1 divides 0x3F800000 by 0x40800000.
- Required: port 0 served first with rd0=0x40000000; then port 1 with rd1=0x3E800000; rd0 unchanged during port 1's completion.
REQ-033 Sustained contention:
- Stimulus: both orders held high, re-raised after each accepted, for 6 operations.
- Required: grant order 0,1,0,1,0,1.
REQ-034 Back-pressure:
- Stimulus: fdiv model holds u_accepted low for 5 cycles.
- Required: u_order high and u_rs1/u_rs2 stable for all 5 cycles; accepted1 stays 0 while order1 is high.
REQ-035 Reset in flight:
- Stimulus: drop rstn while in BUSY, then raise it.
- Required: all outputs 0 immediately, no done0/done1 afterwards, and a new order1 is accepted in the first post-reset cycle.
REQ-036 Same-cycle edges:
- Stimulus: u_accepted and u_done both high in the ISSUE cycle; also a stray u_done while in IDLE.
- Required: done pulses exactly 2 cycles after the accept; the stray u_done causes no done and no rd change.
